sha256_accel_core: RTL and testbench

Single-block SHA-256 compression engine (FIPS 180-4) that forms the hashing datapath of the crypto accelerator in the Caravel user project area. Firmware on the management SoC loads a pre-padded 512-bit message block, starts a new hash or continues a chained one, waits for ready, and reads back the 256-bit digest. Processing runs one round per clock. Padding, length encoding and bus decoding are handled outside this block.

---
 rtl/sha256_accel_core.sv | 150 +++++++++++++++
 tb/tb_sha256_accel_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_accel_core.sv
// ============================================================================
// sha256_accel_core : single-block SHA-256 compression engine, one round/clk
// Rev 1.0
// ============================================================================
`default_nettype none

module sha256_accel_core (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         init_i,
    input  logic         next_i,
    input  logic [511:0] block_i,
    output logic         ready_o,
    output logic [255:0] digest_o,
    output logic         digest_valid_o
);

    localparam logic [255:0] H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // K0 occupies the most significant word so K_t sits at bit (63-t)*32.
    localparam logic [2047:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUNDS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state_q;
    logic [5:0]         round_q;
    logic [0:7][31:0]   h_q;
    logic [0:7][31:0]   v_q;
    logic [0:7][31:0]   v_d;
    logic [0:15][31:0]  w_q;
    logic [0:15][31:0]  w_d;
    logic               ready_q;
    logic               valid_q;

    logic [31:0]        w_k;
    logic [31:0]        w_t1;
    logic [31:0]        w_t2;
    logic [31:0]        w_sched;

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign w_k = K_TABLE[{~round_q, 5'b00000} +: 32];

    // w_q[0] is always W_t; the window slides every round and appends W_{t+16}.
    always_comb begin
        w_t1    = v_q[7] + big_sigma1(v_q[4])
                + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
                + w_k + w_q[0];
        w_t2    = big_sigma0(v_q[0])
                + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_sched = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
        v_d     = {w_t1 + w_t2, v_q[0], v_q[1], v_q[2],
                   v_q[3] + w_t1, v_q[4], v_q[5], v_q[6]};
        w_d     = {w_q[1:15], w_sched};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            round_q <= 6'd0;
            h_q     <= '0;
            v_q     <= '0;
            w_q     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (init_i || next_i) begin
                        if (init_i) begin
                            h_q <= H_INIT;
                            v_q <= H_INIT;
                        end else begin
                            v_q <= h_q;
                        end
                        w_q     <= block_i;
                        round_q <= 6'd0;
                        ready_q <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= ST_ROUNDS;
                    end
                end
                ST_ROUNDS: begin
                    v_q     <= v_d;
                    w_q     <= w_d;
                    round_q <= round_q + 6'd1;
                    if (round_q == 6'd63) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    for (int i = 0; i < 8; i++) begin
                        h_q[i] <= h_q[i] + v_q[i];
                    end
                    ready_q <= 1'b1;
                    valid_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o        = ready_q;
    assign digest_valid_o = valid_q;
    assign digest_o       = h_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_accel_core.sv
// ============================================================================
// tb_sha256_accel_core : known-answer and randomized checks of the SHA-256 core
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sha256_accel_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         init;
    logic         next;
    logic [511:0] block;
    logic         ready;
    logic [255:0] digest;
    logic         valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sha256_accel_core dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .init_i         (init),
        .next_i         (next),
        .block_i        (block),
        .ready_o        (ready),
        .digest_o       (digest),
        .digest_valid_o (valid)
    );

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] H0V = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [511:0] MB1_BLK   = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] MB2_BLK   = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] MB_DIG    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-entry message schedule, then 64 rounds.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] hv [8];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] hout;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) begin
            hv[i] = hin[255 - 32*i -: 32];
            v[i]  = hv[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hv[i] + v[i];
        return hout;
    endfunction

    function automatic logic [511:0] rnd_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a command, verify it was accepted, wait for completion and check
    // latency, stability of digest while busy, and the final digest.
    task automatic run(input string tag, input logic ini, input logic nxt,
                       input logic [511:0] blk, input logic [255:0] h_acc,
                       input logic [255:0] exp, input bit disturb);
        int cyc;
        @(negedge clk);
        init  = ini;
        next  = nxt;
        block = blk;
        @(posedge clk);
        #1;
        init  = 1'b0;
        next  = 1'b0;
        block = ~blk;
        chk({tag, " ready_low"}, 256'(ready), 256'(0));
        chk({tag, " valid_low"}, 256'(valid), 256'(0));
        chk({tag, " h_after_accept"}, digest, h_acc);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (disturb && cyc == 5) begin
                init  = 1'b1;
                next  = 1'b1;
                block = rnd_blk();
            end
            if (disturb && cyc == 30) begin
                init = 1'b0;
                next = 1'b0;
            end
            if (cyc == 40) chk({tag, " digest_stable"}, digest, h_acc);
        end
        chk({tag, " latency"}, 256'(cyc), 256'(65));
        chk({tag, " valid"}, 256'(valid), 256'(1));
        chk({tag, " digest"}, digest, exp);
    endtask

    initial begin
        logic [511:0] b;
        logic [255:0] mh;
        logic [255:0] prev;

        rst   = 1'b1;
        init  = 1'b0;
        next  = 1'b0;
        block = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 256'(ready), 256'(1));
        chk("reset valid", 256'(valid), 256'(0));
        chk("reset digest", digest, 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // next straight out of reset chains from H = 0
        b  = rnd_blk();
        mh = ref_compress(256'(0), b);
        run("next_after_reset", 1'b0, 1'b1, b, 256'(0), mh, 1'b0);

        run("abc", 1'b1, 1'b0, ABC_BLK, H0V, ABC_DIG, 1'b0);
        run("empty", 1'b1, 1'b0, EMPTY_BLK, H0V, EMPTY_DIG, 1'b0);
        mh = ref_compress(H0V, MB1_BLK);
        run("two_block_1", 1'b1, 1'b0, MB1_BLK, H0V, mh, 1'b0);
        run("two_block_2", 1'b0, 1'b1, MB2_BLK, mh, MB_DIG, 1'b0);
        run("abc_disturbed", 1'b1, 1'b0, ABC_BLK, H0V, ABC_DIG, 1'b1);
        run("init_and_next", 1'b1, 1'b1, EMPTY_BLK, H0V, EMPTY_DIG, 1'b0);

        // abort in the middle of the rounds
        @(negedge clk);
        init  = 1'b1;
        block = ABC_BLK;
        @(posedge clk);
        #1;
        init = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort ready", 256'(ready), 256'(1));
        chk("abort valid", 256'(valid), 256'(0));
        chk("abort digest", digest, 256'(0));
        @(negedge clk);
        rst = 1'b0;
        run("abc_after_abort", 1'b1, 1'b0, ABC_BLK, H0V, ABC_DIG, 1'b0);

        // random chained messages against the reference model
        for (int k = 0; k < 3; k++) begin
            b  = rnd_blk();
            mh = ref_compress(H0V, b);
            run("rand_init", 1'b1, 1'b0, b, H0V, mh, 1'b0);
            for (int j = 0; j < 2; j++) begin
                b    = rnd_blk();
                prev = mh;
                mh   = ref_compress(prev, b);
                run("rand_next", 1'b0, 1'b1, b, prev, mh, (j == 1));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
